sc_homecount: RTL and testbench

SC_HOMECOUNT -- requirements
Module: SC_HOMECOUNT

---
 rtl/sc_homecount.sv | 143 ++++++++++++++
 tb/tb_sc_homecount.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_homecount.sv
// Home-row arrival counter: accepts frog arrivals into home slots, flags a win for HOLD_CYCLES cycles.
// Optional macro SC_HOMECOUNT_DUPGUARD_EN rejects repeat arrivals to an already occupied slot.
module sc_homecount #(
   parameter int                            DATAWIDTH_ESTADO = 3,
   parameter logic [DATAWIDTH_ESTADO-1:0]   ESTADO_HOME      = 3'b111,
   parameter int                            NUMHOMES         = 4,
   parameter int                            DATAWIDTH_SLOT   = 2,
   parameter int                            GOAL             = 4,
   parameter int                            DATAWIDTH_COUNT  = 3,
   parameter int                            HOLD_CYCLES      = 8
) (
   input  logic                          SC_HOMECOUNT_CLOCK_50,
   input  logic                          SC_HOMECOUNT_RESET,
   input  logic [DATAWIDTH_ESTADO-1:0]   SC_HOMECOUNT_ESTADO_IN,
   input  logic                          SC_HOMECOUNT_RANAINI_IN,
   input  logic [DATAWIDTH_SLOT-1:0]     SC_HOMECOUNT_SLOT_IN,
   input  logic                          SC_HOMECOUNT_PERDIO_IN,
   output logic                          SC_GANO_OUT,
   output logic [DATAWIDTH_COUNT-1:0]    SC_HOMECOUNT_COUNT_OUT,
   output logic [NUMHOMES-1:0]           SC_HOMECOUNT_MASK_OUT,
   output logic                          SC_HOMECOUNT_ACCEPT_OUT
);

   localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int SLOT_W1 = DATAWIDTH_SLOT + 1;
   localparam logic [TIMER_W-1:0]         TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [DATAWIDTH_COUNT-1:0] GOAL_M1    = DATAWIDTH_COUNT'(GOAL - 1);
   localparam logic [SLOT_W1-1:0]         NUMHOMES_S = SLOT_W1'(NUMHOMES);

   typedef enum logic {
      ST_PLAY = 1'b0,
      ST_WIN  = 1'b1
   } state_t;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [DATAWIDTH_COUNT-1:0]    r_count;
   logic [DATAWIDTH_COUNT-1:0]    w_count_nxt;
   logic [NUMHOMES-1:0]           r_mask;
   logic [NUMHOMES-1:0]           w_mask_nxt;
   logic [TIMER_W-1:0]            r_timer;
   logic [TIMER_W-1:0]            w_timer_nxt;
   logic                          r_gano;
   logic                          w_gano_nxt;
   logic                          r_accept;
   logic                          w_accept_nxt;

   logic                          w_slot_ok;
   logic [NUMHOMES-1:0]           w_slot_bit;
   logic                          w_dup_ok;
   logic                          w_candidate;
   logic                          w_accept;
   logic                          w_reach_goal;

   assign w_slot_ok   = {1'b0, SC_HOMECOUNT_SLOT_IN} < NUMHOMES_S;
   assign w_slot_bit  = NUMHOMES'(1) << SC_HOMECOUNT_SLOT_IN;
   assign w_candidate = (SC_HOMECOUNT_ESTADO_IN == ESTADO_HOME) &&
                        SC_HOMECOUNT_RANAINI_IN && w_slot_ok;

`ifdef SC_HOMECOUNT_DUPGUARD_EN
   assign w_dup_ok = ((r_mask & w_slot_bit) == '0);
`else
   assign w_dup_ok = 1'b1;
`endif

   // A loss in the same cycle always wins over an arrival.
   assign w_accept     = (r_state == ST_PLAY) && !SC_HOMECOUNT_PERDIO_IN &&
                         w_candidate && w_dup_ok;
   assign w_reach_goal = (r_count == GOAL_M1);

   always_ff @(posedge SC_HOMECOUNT_CLOCK_50) begin
      if (SC_HOMECOUNT_RESET) begin
         r_state  <= ST_PLAY;
         r_count  <= '0;
         r_mask   <= '0;
         r_timer  <= '0;
         r_gano   <= 1'b0;
         r_accept <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_mask   <= w_mask_nxt;
         r_timer  <= w_timer_nxt;
         r_gano   <= w_gano_nxt;
         r_accept <= w_accept_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_PLAY: if (w_accept && w_reach_goal) w_state_nxt = ST_WIN;
         ST_WIN:  if (r_timer == '0)            w_state_nxt = ST_PLAY;
         default:                               w_state_nxt = ST_PLAY;
      endcase
   end

   // Next values of the registered outputs; the win flag mirrors the next state.
   always_comb begin
      w_count_nxt  = r_count;
      w_mask_nxt   = r_mask;
      w_timer_nxt  = r_timer;
      w_accept_nxt = 1'b0;
      w_gano_nxt   = 1'b0;
      case (r_state)
         ST_PLAY: begin
            if (SC_HOMECOUNT_PERDIO_IN) begin
               w_count_nxt = '0;
               w_mask_nxt  = '0;
            end else if (w_accept) begin
               w_count_nxt  = r_count + DATAWIDTH_COUNT'(1);
               w_mask_nxt   = r_mask | w_slot_bit;
               w_accept_nxt = 1'b1;
               if (w_reach_goal) begin
                  w_timer_nxt = TIMER_LOAD;
                  w_gano_nxt  = 1'b1;
               end
            end
         end
         ST_WIN: begin
            if (r_timer == '0) begin
               w_count_nxt = '0;
               w_mask_nxt  = '0;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer - TIMER_W'(1);
               w_gano_nxt  = 1'b1;
            end
         end
         default: begin
            w_count_nxt = '0;
            w_mask_nxt  = '0;
            w_timer_nxt = '0;
         end
      endcase
   end

   assign SC_GANO_OUT             = r_gano;
   assign SC_HOMECOUNT_COUNT_OUT  = r_count;
   assign SC_HOMECOUNT_MASK_OUT   = r_mask;
   assign SC_HOMECOUNT_ACCEPT_OUT = r_accept;

endmodule

// File: tb/tb_sc_homecount.sv
// Directed bench for sc_homecount; slot width 3 so out-of-range slot indices can be driven.
module tb_sc_homecount;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] estado;
   logic       ranaini;
   logic [2:0] slot;
   logic       perdio;
   logic       gano;
   logic [2:0] count;
   logic [3:0] mask;
   logic       accept;

   int n_checks = 0;
   int n_errors = 0;

   logic       eg, ea;
   logic [2:0] ec;
   logic [3:0] em;

   always #5 clk = ~clk;

   sc_homecount #(
      .DATAWIDTH_ESTADO (3),
      .ESTADO_HOME      (3'b111),
      .NUMHOMES         (4),
      .DATAWIDTH_SLOT   (3),
      .GOAL             (4),
      .DATAWIDTH_COUNT  (3),
      .HOLD_CYCLES      (8)
   ) dut (
      .SC_HOMECOUNT_CLOCK_50   (clk),
      .SC_HOMECOUNT_RESET      (rst),
      .SC_HOMECOUNT_ESTADO_IN  (estado),
      .SC_HOMECOUNT_RANAINI_IN (ranaini),
      .SC_HOMECOUNT_SLOT_IN    (slot),
      .SC_HOMECOUNT_PERDIO_IN  (perdio),
      .SC_GANO_OUT             (gano),
      .SC_HOMECOUNT_COUNT_OUT  (count),
      .SC_HOMECOUNT_MASK_OUT   (mask),
      .SC_HOMECOUNT_ACCEPT_OUT (accept)
   );

   // Apply one cycle of inputs, then return 1 time unit after the capturing edge.
   task automatic drive(input logic r, input logic [2:0] e, input logic a,
                        input logic [2:0] s, input logic p);
      rst = r; estado = e; ranaini = a; slot = s; perdio = p;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 3'b000, 1'b0, 3'd0, 1'b0);
      drive(1'b1, 3'b111, 1'b1, 3'd1, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== 9'b0) begin
         n_errors++;
         $display("FAIL reset_hold got gano=%0b acc=%0b cnt=%0d mask=%b want all 0", gano, accept, count, mask);
      end
      drive(1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== 9'b0) begin
         n_errors++;
         $display("FAIL reset_release got gano=%0b acc=%0b cnt=%0d mask=%b want all 0", gano, accept, count, mask);
      end
   endtask

   task automatic test_four_arrivals();
      em = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 3'b111, 1'b1, 3'(i), 1'b0);
         em = em | (4'b0001 << i);
         eg = (i == 3); ea = 1'b1; ec = 3'(i + 1);
         n_checks++;
         if ({gano, accept, count, mask} !== {eg, ea, ec, em}) begin
            n_errors++;
            $display("FAIL arrive_%0d got %b_%b_%0d_%b want %b_%b_%0d_%b", i, gano, accept, count, mask, eg, ea, ec, em);
         end
         if (i < 3) begin
            drive(1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
            n_checks++;
            if ({gano, accept, count, mask} !== {1'b0, 1'b0, ec, em}) begin
               n_errors++;
               $display("FAIL idle_after_%0d got %b_%b_%0d_%b want 0_0_%0d_%b", i, gano, accept, count, mask, ec, em);
            end
         end
      end
      // Remaining seven win cycles, with arrivals and losses that must be ignored.
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, 3'b111, 1'b1, 3'(k % 4), 1'(k % 2));
         n_checks++;
         if ({gano, accept, count, mask} !== {1'b1, 1'b0, 3'd4, 4'b1111}) begin
            n_errors++;
            $display("FAIL win_hold_%0d got %b_%b_%0d_%b want 1_0_4_1111", k, gano, accept, count, mask);
         end
      end
      drive(1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== 9'b0) begin
         n_errors++;
         $display("FAIL win_exit got %b_%b_%0d_%b want 0_0_0_0000", gano, accept, count, mask);
      end
   endtask

   task automatic test_loss();
      drive(1'b0, 3'b111, 1'b1, 3'd0, 1'b0);
      drive(1'b0, 3'b111, 1'b1, 3'd1, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== {1'b0, 1'b1, 3'd2, 4'b0011}) begin
         n_errors++;
         $display("FAIL loss_pre got %b_%b_%0d_%b want 0_1_2_0011", gano, accept, count, mask);
      end
      drive(1'b0, 3'b111, 1'b1, 3'd2, 1'b1);
      n_checks++;
      if ({gano, accept, count, mask} !== 9'b0) begin
         n_errors++;
         $display("FAIL loss_clear got %b_%b_%0d_%b want 0_0_0_0000", gano, accept, count, mask);
      end
      drive(1'b0, 3'b111, 1'b1, 3'd3, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== {1'b0, 1'b1, 3'd1, 4'b1000}) begin
         n_errors++;
         $display("FAIL loss_resume got %b_%b_%0d_%b want 0_1_1_1000", gano, accept, count, mask);
      end
   endtask

   task automatic test_dup();
      drive(1'b0, 3'b000, 1'b0, 3'd0, 1'b1);
      drive(1'b0, 3'b111, 1'b1, 3'd2, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== {1'b0, 1'b1, 3'd1, 4'b0100}) begin
         n_errors++;
         $display("FAIL dup_first got %b_%b_%0d_%b want 0_1_1_0100", gano, accept, count, mask);
      end
      drive(1'b0, 3'b111, 1'b1, 3'd2, 1'b0);
`ifdef SC_HOMECOUNT_DUPGUARD_EN
      ea = 1'b0; ec = 3'd1;
`else
      ea = 1'b1; ec = 3'd2;
`endif
      n_checks++;
      if ({gano, accept, count, mask} !== {1'b0, ea, ec, 4'b0100}) begin
         n_errors++;
         $display("FAIL dup_second got %b_%b_%0d_%b want 0_%b_%0d_0100", gano, accept, count, mask, ea, ec);
      end
   endtask

   task automatic test_edge_inputs();
      logic [2:0] est_v [4] = '{3'b000, 3'b011, 3'b111, 3'b111};
      logic       ran_v [4] = '{1'b0,   1'b1,   1'b1,   1'b0};
      logic [2:0] slt_v [4] = '{3'd0,   3'd0,   3'd4,   3'd1};
      drive(1'b0, 3'b000, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, est_v[i], ran_v[i], slt_v[i], 1'b0);
         n_checks++;
         if ({gano, accept, count, mask} !== 9'b0) begin
            n_errors++;
            $display("FAIL edge_reject_%0d got %b_%b_%0d_%b want 0_0_0_0000", i, gano, accept, count, mask);
         end
      end
      drive(1'b0, 3'b111, 1'b1, 3'd7, 1'b0);
      drive(1'b0, 3'b111, 1'b1, 3'd1, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== {1'b0, 1'b1, 3'd1, 4'b0010}) begin
         n_errors++;
         $display("FAIL edge_accept got %b_%b_%0d_%b want 0_1_1_0010", gano, accept, count, mask);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 3'(i), 1'b0, 3'd0, 1'b0);
         n_checks++;
         if ({gano, accept, count, mask} !== {1'b0, 1'b0, 3'd1, 4'b0010}) begin
            n_errors++;
            $display("FAIL edge_hold_%0d got %b_%b_%0d_%b want 0_0_1_0010", i, gano, accept, count, mask);
         end
      end
   endtask

   task automatic test_reset_in_win();
      drive(1'b0, 3'b000, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b0, 3'b111, 1'b1, 3'(i), 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
         n_checks++;
         if ({gano, accept, count, mask} !== {1'b1, 1'b0, 3'd4, 4'b1111}) begin
            n_errors++;
            $display("FAIL rwin_pre_%0d got %b_%b_%0d_%b want 1_0_4_1111", i, gano, accept, count, mask);
         end
      end
      drive(1'b1, 3'b111, 1'b1, 3'd0, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== 9'b0) begin
         n_errors++;
         $display("FAIL rwin_reset got %b_%b_%0d_%b want 0_0_0_0000", gano, accept, count, mask);
      end
      drive(1'b0, 3'b111, 1'b1, 3'd0, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== {1'b0, 1'b1, 3'd1, 4'b0001}) begin
         n_errors++;
         $display("FAIL rwin_after got %b_%b_%0d_%b want 0_1_1_0001", gano, accept, count, mask);
      end
      drive(1'b0, 3'b000, 1'b0, 3'd0, 1'b0);
      n_checks++;
      if ({gano, accept, count, mask} !== {1'b0, 1'b0, 3'd1, 4'b0001}) begin
         n_errors++;
         $display("FAIL rwin_pulse got %b_%b_%0d_%b want 0_0_1_0001", gano, accept, count, mask);
      end
   endtask

   initial begin
      rst = 1'b1; estado = 3'b000; ranaini = 1'b0; slot = 3'd0; perdio = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_four_arrivals();
      test_loss();
      test_dup();
      test_edge_inputs();
      test_reset_in_win();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
